rv_ctl_hs: RTL
==============

// Module: rv_ctl_hs
// PURPOSE
// - Multicycle RISC-V control FSM with a req/ready memory handshake. Each memory access stalls until mem_ready.
// - A watchdog traps accesses that stall too long.
// - Adds BNE alongside BEQ. Optional ALU-immediate (I-type) support.
// - Sits between the multicycle datapath (instr/zero in, mux selects and enables out) and a variable-latency memory.
// PARAMETERS
// - TIMEOUT  15  Max consecutive wait cycles per access before TRAP. 0 disables the watchdog.
// - TO_W      8  Watchdog counter width. Must satisfy TIMEOUT < 2**TO_W.
// PORTS
// - clk        in   1   clock
// - rst        in   1   synchronous reset, active-high
// - instr      in   32  IR contents
// - zero       in   1   ALU zero flag
// - mem_ready  in   1   memory completes the current access this cycle
// - mem_req    out  1   memory access request
// - memrw      out  1   1 = write (valid only with mem_req)
// - pcsource   out  1   PC_INC / PC_ALU
// - pcwrite, pccen, irwrite, mdrwrite, regwen  out  1  register enables
// - wbsel      out  2   WB_PC / WB_ALUOUT / WB_MDR
// - immsel     out  2   IMM_L(I) / IMM_S / IMM_B / IMM_J
// - asel       out  1   ALUA_REG / ALUA_PCC
// - bsel       out  1   ALUB_REG / ALUB_IMM
// - alusel     out  4   ALU operation
// - neg_en     out  1   store-negated (SW2) data path enable
// - instret    out  1   one-cycle pulse when an instruction retires
// - err        out  1   sticky trap flag
// BEHAVIOUR
// - Single clock; all state updates on posedge clk.
// - rst=1: state<=FETCH, watchdog<=0, err<=0. While rst is high, all outputs are forced to their defaults:
//   - enables, mem_req, memrw, neg_en, instret, err = 0
//   - pcsource=PC_INC, wbsel=WB_PC, immsel=IMM_B, asel=ALUA_REG, bsel=ALUB_REG, alusel=ALU_ADD
// - Outputs are combinational from state, instr, zero and mem_ready. Every state starts from the defaults above.
// - Handshake: mem_req stays high for the whole memory state. The access completes in the first cycle with mem_ready=1.
//   - mem_ready with mem_req=0 is ignored.
//   - A zero-wait memory (mem_ready tied 1) reproduces the classic 1-cycle access.
// - States and transitions:
//   - FETCH: mem_req=1.
//     - If mem_ready: irwrite=pcwrite=pccen=1, pcsource=PC_INC, ->DECODE.
//     - Else: stay, no enables.
//   - DECODE: immsel=IMM_B, asel=PCC, bsel=IMM, ADD. Next state by opcode/funct3:
//     - LW/SW/SW2 -> LSW_ADDR
//     - R-type -> RTYPE_ALU
//     - BEQ/BNE -> BR_EXEC
//     - JAL -> JAL_EXEC
//     - I-type ALU -> ITYPE_ALU (macro only)
//     - anything else -> FETCH with instret=1 (executed as NOP)
//   - LSW_ADDR: immsel = IMM_L for LW, IMM_S otherwise. asel=REG, bsel=IMM, ADD. Next: LW->LW_MEM, SW->SW_MEM, SW2->SW2_MEM.
//   - LW_MEM: mem_req=1. mdrwrite=mem_ready. On mem_ready -> LW_WB.
//   - LW_WB: wbsel=MDR, regwen=1, instret=1, ->FETCH.
//   - SW_MEM / SW2_MEM: mem_req=memrw=1 (SW2 also neg_en=1). On mem_ready: instret=1, ->FETCH.
//   - RTYPE_ALU: REG/REG, alusel={instr[14:12],instr[30]}, ->ALU_WB.
//   - ALU_WB: wbsel=ALUOUT, regwen=1, instret=1, ->FETCH.
//   - BR_EXEC: REG/REG, SUB, pcsource=PC_ALU, instret=1, ->FETCH.
//     - pcwrite = zero when funct3=000 (BEQ); pcwrite = ~zero when funct3=001 (BNE).
//   - JAL_EXEC: IMM_J, PCC, IMM, ADD, pcsource=PC_ALU, pcwrite=regwen=1, wbsel=PC, instret=1, ->FETCH.
//   - TRAP: all outputs at defaults except err=1. Stays until rst.
// - Watchdog (TIMEOUT>0): counts consecutive cycles in FETCH/LW_MEM/SW_MEM/SW2_MEM with mem_ready=0.
//   - Clears on mem_ready or on any state change.
//   - When count==TIMEOUT and mem_ready=0: ->TRAP at the next edge, err sticky.
//   - mem_ready on the TIMEOUT cycle still completes the access normally (ready has priority).
// - Reset mid-access: mem_req drops in the same cycle rst is seen. The pending memory response is discarded.
// CONFIGURATION
// - RV_CTL_ITYPE_EN defined: opcode 0010011 decodes to ITYPE_ALU (IMM_L, REG/IMM) then ALU_WB.
//   - alusel={funct3, funct3==101 ? instr[30] : 1'b0}.
// - RV_CTL_ITYPE_EN undefined: opcode 0010011 falls to the default decode (NOP, instret=1). ITYPE_ALU state is absent.
// STRUCTURE
// - rv_ctl_pkg: state enum, opcode/funct3 match constants (LW, SW, SW2, ALU, BEQ, BNE, JAL, ALUI), select encodings.
// - Sub-module rv_ctl_wdog: watchdog counter.
//   - Inputs: clk, rst, waiting, clear.
//   - Output: expire.
//   - Parameters: TIMEOUT, TO_W.
// TESTING
// - mem_ready=1 always, LW x1,4(x2): FETCH,DECODE,LSW_ADDR,LW_MEM,LW_WB. 5 cycles, mdrwrite 1 cycle, one instret.
// - SW with mem_ready low for 3 cycles: mem_req=memrw=1 for 4 cycles, instret only in the 4th, no err.
// - BNE, zero=0 -> pcwrite=1. zero=1 -> pcwrite=0. BEQ gives the opposite in both cases.
// - TIMEOUT=15, mem_ready held 0 in FETCH: TRAP entered after 16 wait cycles, err=1 until rst. Ready on cycle 16 -> no trap.
// - rst asserted during LW_MEM wait: next cycle state=FETCH, mem_req low while rst=1, err=0.
// - ADDI with macro: ALU_WB regwen=1, alusel=0000. Without macro: DECODE->FETCH, no regwen, instret=1.

Source files
------------

// File: rtl/rv_ctl_hs_pkg.sv
// Shared types and encodings for the rv_ctl_hs multicycle controller.
// RV_CTL_ITYPE_EN adds the ITYPE_ALU state and I-type ALU decode.
package rv_ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_LSW_ADDR,
    S_LW_MEM,
    S_LW_WB,
    S_SW_MEM,
    S_SW2_MEM,
    S_RTYPE_ALU,
    S_ALU_WB,
    S_BR_EXEC,
    S_JAL_EXEC,
    S_TRAP
`ifdef RV_CTL_ITYPE_EN
    , S_ITYPE_ALU
`endif
  } state_e;

  typedef enum logic [2:0] {
    IC_NOP, IC_LW, IC_SW, IC_SW2, IC_ALU, IC_BR, IC_JAL, IC_ALUI
  } iclass_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // SW2 reuses the store opcode with a funct3 that RV32 leaves unused.
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SW2 = 3'b110;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic       PC_INC    = 1'b0;
  localparam logic       PC_ALU    = 1'b1;
  localparam logic [1:0] WB_PC     = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;
  localparam logic [1:0] IMM_L     = 2'd0;
  localparam logic [1:0] IMM_S     = 2'd1;
  localparam logic [1:0] IMM_B     = 2'd2;
  localparam logic [1:0] IMM_J     = 2'd3;
  localparam logic       ALUA_REG  = 1'b0;
  localparam logic       ALUA_PCC  = 1'b1;
  localparam logic       ALUB_REG  = 1'b0;
  localparam logic       ALUB_IMM  = 1'b1;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;

  function automatic iclass_e decode_class(input logic [6:0] op, input logic [2:0] f3);
    iclass_e c;
    c = IC_NOP;
    case (op)
      OP_LOAD:   if (f3 == F3_LW) c = IC_LW;
      OP_STORE:  if (f3 == F3_SW) c = IC_SW; else if (f3 == F3_SW2) c = IC_SW2;
      OP_ALU:    c = IC_ALU;
      OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) c = IC_BR;
      OP_JAL:    c = IC_JAL;
`ifdef RV_CTL_ITYPE_EN
      OP_ALUI:   c = IC_ALUI;
`endif
      default:   c = IC_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_ctl_hs_if.sv
// Memory request/ready handshake between the controller and a variable-latency memory.
interface rv_ctl_hs_if;
  logic mem_req;
  logic memrw;
  logic mem_ready;

  modport master (output mem_req, output memrw, input mem_ready);
  modport slave  (input mem_req, input memrw, output mem_ready);
endinterface

// File: rtl/rv_ctl_wdog.sv
// Counts consecutive stalled memory cycles; expire fires on the last tolerated stall cycle.
module rv_ctl_wdog #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic clear,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, waiting, clear};
      assign expire = 1'b0;
    end else begin : g_on
      logic [TO_W-1:0] cnt_q;
      logic [TO_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
          cnt_d = '0;
        end else if (waiting) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire = waiting && (cnt_q == TO_W'(TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/rv_ctl_hs.sv
// Multicycle RISC-V control FSM with req/ready memory handshake and stall watchdog.
// Optional I-type ALU support is enabled by defining RV_CTL_ITYPE_EN.
module rv_ctl_hs
  import rv_ctl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              zero,
  rv_ctl_hs_if.master       mem,
  output logic              pcsource,
  output logic              pcwrite,
  output logic              pccen,
  output logic              irwrite,
  output logic              mdrwrite,
  output logic              regwen,
  output logic [1:0]        wbsel,
  output logic [1:0]        immsel,
  output logic              asel,
  output logic              bsel,
  output logic [3:0]        alusel,
  output logic              neg_en,
  output logic              instret,
  output logic              err
);

  state_e      state_q, state_d;
  iclass_e     cls;
  logic [2:0]  f3;
  logic        mem_ready;
  logic        mem_req;
  logic        memrw;
  logic        in_mem_state;
  logic        wd_expire;
  logic        unused_instr;

  assign f3           = instr[14:12];
  assign cls          = decode_class(instr[6:0], f3);
  assign mem_ready    = mem.mem_ready;
  assign mem.mem_req  = mem_req;
  assign mem.memrw    = memrw;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_LW_MEM) ||
                        (state_q == S_SW_MEM) || (state_q == S_SW2_MEM);

  rv_ctl_wdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .waiting (in_mem_state && !mem_ready),
    .clear   (mem_ready || (state_d != state_q)),
    .expire  (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready wins over the watchdog on the final tolerated stall cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (cls)
          IC_LW, IC_SW, IC_SW2: state_d = S_LSW_ADDR;
          IC_ALU:               state_d = S_RTYPE_ALU;
          IC_BR:                state_d = S_BR_EXEC;
          IC_JAL:               state_d = S_JAL_EXEC;
`ifdef RV_CTL_ITYPE_EN
          IC_ALUI:              state_d = S_ITYPE_ALU;
`endif
          default:              state_d = S_FETCH;
        endcase
      end
      S_LSW_ADDR: begin
        if (cls == IC_LW)       state_d = S_LW_MEM;
        else if (cls == IC_SW2) state_d = S_SW2_MEM;
        else                    state_d = S_SW_MEM;
      end
      S_LW_MEM: begin
        if (mem_ready)      state_d = S_LW_WB;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_SW_MEM, S_SW2_MEM: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_RTYPE_ALU: state_d = S_ALU_WB;
`ifdef RV_CTL_ITYPE_EN
      S_ITYPE_ALU: state_d = S_ALU_WB;
`endif
      S_LW_WB, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    memrw    = 1'b0;
    pcsource = PC_INC;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    mdrwrite = 1'b0;
    regwen   = 1'b0;
    wbsel    = WB_PC;
    immsel   = IMM_B;
    asel     = ALUA_REG;
    bsel     = ALUB_REG;
    alusel   = ALU_ADD;
    neg_en   = 1'b0;
    instret  = 1'b0;
    err      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            irwrite  = 1'b1;
            pcwrite  = 1'b1;
            pccen    = 1'b1;
            pcsource = PC_INC;
          end
        end
        S_DECODE: begin
          immsel  = IMM_B;
          asel    = ALUA_PCC;
          bsel    = ALUB_IMM;
          alusel  = ALU_ADD;
          instret = (cls == IC_NOP);
`ifndef RV_CTL_ITYPE_EN
          instret = (cls == IC_NOP) || (cls == IC_ALUI);
`endif
        end
        S_LSW_ADDR: begin
          immsel = (cls == IC_LW) ? IMM_L : IMM_S;
          bsel   = ALUB_IMM;
        end
        S_LW_MEM: begin
          mem_req  = 1'b1;
          mdrwrite = mem_ready;
        end
        S_LW_WB: begin
          wbsel   = WB_MDR;
          regwen  = 1'b1;
          instret = 1'b1;
        end
        S_SW_MEM, S_SW2_MEM: begin
          mem_req = 1'b1;
          memrw   = 1'b1;
          neg_en  = (state_q == S_SW2_MEM);
          instret = mem_ready;
        end
        S_RTYPE_ALU: begin
          alusel = {f3, instr[30]};
        end
`ifdef RV_CTL_ITYPE_EN
        S_ITYPE_ALU: begin
          immsel = IMM_L;
          bsel   = ALUB_IMM;
          alusel = {f3, (f3 == F3_SRX) ? instr[30] : 1'b0};
        end
`endif
        S_ALU_WB: begin
          wbsel   = WB_ALUOUT;
          regwen  = 1'b1;
          instret = 1'b1;
        end
        S_BR_EXEC: begin
          alusel   = ALU_SUB;
          pcsource = PC_ALU;
          pcwrite  = (f3 == F3_BNE) ? ~zero : zero;
          instret  = 1'b1;
        end
        S_JAL_EXEC: begin
          immsel   = IMM_J;
          asel     = ALUA_PCC;
          bsel     = ALUB_IMM;
          pcsource = PC_ALU;
          pcwrite  = 1'b1;
          regwen   = 1'b1;
          wbsel    = WB_PC;
          instret  = 1'b1;
        end
        S_TRAP:  err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
